mem_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch requester (I) and the data load/store requester (D) of the pipelined core.
- Sits between the control/data paths and the single-ported memory or bus.
- One outstanding transaction at a time: a request is accepted, issued downstream, its response is routed back to the owner, then the arbiter frees.
- D has priority because it stalls the whole pipeline; a starvation counter guarantees I forward progress.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between the instruction-fetch requester (I) and the
// data load/store requester (D). One transaction is in flight at a time:
// accept (IDLE) -> issue downstream (ISSUE) -> route response (WAIT_RES).
// D normally wins because a data stall freezes the whole pipeline. A
// starvation counter forces an I grant after MAX_STARVE consecutive D grants
// that each left I waiting.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   i_req_* / i_res_*     instruction fetch request / response
//   d_req_* / d_res_*     data load/store request / response
//   m_req_* / m_res_*     downstream memory request / response
//   owner                 current or last owner (0 = I, 1 = D)
//   err_spurious          pulse when a response arrives outside WAIT_RES
module mem_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MAX_STARVE = 4,     // 1..15
   parameter logic [2:0]  IFETCH_TYP = 3'd6
) (
   input  logic              clk,
   input  logic              reset,
   // instruction fetch requester
   input  logic              i_req_valid,
   output logic              i_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   output logic              i_res_valid,
   output logic [DATA_W-1:0] i_res_data,
   // data requester
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   input  logic              d_req_fcn,
   input  logic [2:0]        d_req_typ,
   output logic              d_res_valid,
   output logic [DATA_W-1:0] d_res_data,
   // downstream memory port
   output logic              m_req_valid,
   input  logic              m_req_ready,
   output logic [ADDR_W-1:0] m_req_addr,
   output logic [DATA_W-1:0] m_req_wdata,
   output logic              m_req_fcn,
   output logic [2:0]        m_req_typ,
   input  logic              m_res_valid,
   input  logic [DATA_W-1:0] m_res_data,
   // status
   output logic              owner,
   output logic              err_spurious
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RES = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] starve_cnt;
   logic       grant_i;
   logic       grant_d;
   logic       res_hit;

   // Next state, grant selection and outputs.
   // NOTE: every signal gets a default first so no path leaves one unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt    = state;
      grant_i      = 1'b0;
      grant_d      = 1'b0;
      m_req_valid  = 1'b0;
      res_hit      = 1'b0;
      err_spurious = 1'b0;

      case (state)
         IDLE: begin
            // A grant made while reset is high would never be latched, so the
            // requester must not be told it was accepted.
            if (!reset) begin
               if (i_req_valid && (!d_req_valid || starve_cnt == STARVE_MAX)) begin
                  grant_i = 1'b1;
               end else if (d_req_valid) begin
                  grant_d = 1'b1;
               end
            end
            if (grant_i || grant_d) begin
               state_nxt = ISSUE;
            end
            err_spurious = m_res_valid;
         end
         ISSUE: begin
            m_req_valid  = 1'b1;
            err_spurious = m_res_valid;
            if (m_req_ready) begin
               state_nxt = WAIT_RES;
            end
         end
         WAIT_RES: begin
            if (m_res_valid) begin
               res_hit   = !reset;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign i_req_ready = grant_i;
   assign d_req_ready = grant_d;
   assign i_res_valid = res_hit && !owner;
   assign d_res_valid = res_hit &&  owner;
   // Response data is shared; only the valid strobes are steered.
   assign i_res_data  = m_res_data;
   assign d_res_data  = m_res_data;

   // State, starvation counter and latched request fields.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the latched request fields are reset along with the control
         // state so the downstream port shows known values after reset.
         state       <= IDLE;
         starve_cnt  <= 4'd0;
         owner       <= 1'b0;
         m_req_addr  <= '0;
         m_req_wdata <= '0;
         m_req_fcn   <= 1'b0;
         m_req_typ   <= 3'd0;
      end else begin
         state <= state_nxt;
         if (grant_i) begin
            owner       <= 1'b0;
            m_req_addr  <= i_req_addr;
            m_req_wdata <= '0;
            m_req_fcn   <= 1'b0;
            m_req_typ   <= IFETCH_TYP;
            starve_cnt  <= 4'd0;
         end else if (grant_d) begin
            owner       <= 1'b1;
            m_req_addr  <= d_req_addr;
            m_req_wdata <= d_req_wdata;
            m_req_fcn   <= d_req_fcn;
            m_req_typ   <= d_req_typ;
            // Only a D grant that leaves I waiting counts toward starvation.
            if (i_req_valid && starve_cnt != STARVE_MAX) begin
               starve_cnt <= starve_cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed scenarios (reset values, fetch latency, priority, downstream stall,
// spurious response, reset mid-transaction) followed by a randomized phase in
// which a transaction-level model predicts each grant and response. Expected
// requests/responses are queued by the stimulus side and consumed by a
// separate monitor when the DUT presents them.
module tb_mem_arbiter;

   localparam int MAX_STARVE = 4;

   logic        clk;
   logic        reset;
   logic        i_req_valid;
   logic        i_req_ready;
   logic [31:0] i_req_addr;
   logic        i_res_valid;
   logic [31:0] i_res_data;
   logic        d_req_valid;
   logic        d_req_ready;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic        d_req_fcn;
   logic [2:0]  d_req_typ;
   logic        d_res_valid;
   logic [31:0] d_res_data;
   logic        m_req_valid;
   logic        m_req_ready;
   logic [31:0] m_req_addr;
   logic [31:0] m_req_wdata;
   logic        m_req_fcn;
   logic [2:0]  m_req_typ;
   logic        m_res_valid;
   logic [31:0] m_res_data;
   logic        owner;
   logic        err_spurious;

   mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_STARVE(MAX_STARVE), .IFETCH_TYP(3'd6)
   ) dut (
      .clk(clk), .reset(reset),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .i_res_valid(i_res_valid), .i_res_data(i_res_data),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_fcn(d_req_fcn), .d_req_typ(d_req_typ),
      .d_res_valid(d_res_valid), .d_res_data(d_res_data),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
      .m_req_wdata(m_req_wdata), .m_req_fcn(m_req_fcn), .m_req_typ(m_req_typ),
      .m_res_valid(m_res_valid), .m_res_data(m_res_data),
      .owner(owner), .err_spurious(err_spurious)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        own;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        fcn;
      logic [2:0]  typ;
   } exp_req_t;

   typedef struct {
      logic        own;
      logic [31:0] data;
   } exp_res_t;

   exp_req_t exp_req[$];
   exp_res_t exp_res[$];

   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_resp   = 0;
   logic env_on   = 1'b0;
   logic exp_i_rdy, exp_d_rdy, exp_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: active during the randomized phase, samples 2 time units after
   // the negedge on which the stimulus was applied.
   always @(negedge clk) begin
      if (env_on) begin
         exp_req_t r;
         exp_res_t e;
         #2;
         check("rand_i_ready", i_req_ready, exp_i_rdy);
         check("rand_d_ready", d_req_ready, exp_d_rdy);
         check("rand_err_spurious", err_spurious, exp_err);
         if (m_req_valid && m_req_ready) begin
            if (exp_req.size() == 0) begin
               check("rand_unexpected_req", m_req_valid, 1'b0);
            end else begin
               r = exp_req.pop_front();
               check("rand_req_owner", owner, r.own);
               check("rand_req_addr", m_req_addr, r.addr);
               check("rand_req_wdata", m_req_wdata, r.wdata);
               check("rand_req_fcn", m_req_fcn, r.fcn);
               check("rand_req_typ", m_req_typ, r.typ);
            end
         end
         if (exp_res.size() != 0) begin
            e = exp_res.pop_front();
            check("rand_i_res_valid", i_res_valid, !e.own);
            check("rand_d_res_valid", d_res_valid, e.own);
            check("rand_res_data", e.own ? d_res_data : i_res_data, e.data);
            if (i_res_valid || d_res_valid) n_resp++;
         end else begin
            check("rand_no_res", {i_res_valid, d_res_valid}, 2'b00);
         end
      end
   end

   // Randomized requesters + downstream memory + transaction-level model.
   task automatic run_random(input int cycles);
      bit model_free   = 1'b1;
      bit free_next    = 1'b0;
      bit resp_pending = 1'b0;
      int resp_delay   = 0;
      int starve       = 0;
      bit cur_owner    = 1'b0;
      bit iv, dv;
      env_on = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (free_next) begin
            model_free = 1'b1;
            free_next  = 1'b0;
         end
         // downstream memory
         exp_err     = 1'b0;
         m_res_valid = 1'b0;
         if (resp_pending) begin
            if (resp_delay == 0) begin
               m_res_valid = 1'b1;
               m_res_data  = $urandom;
               exp_res.push_back('{own: cur_owner, data: m_res_data});
               resp_pending = 1'b0;
               free_next    = 1'b1;
            end else begin
               resp_delay--;
            end
         end else if ($urandom_range(0, 19) == 0) begin
            m_res_valid = 1'b1;
            m_res_data  = $urandom;
            exp_err     = 1'b1;
         end
         m_req_ready = ($urandom_range(0, 9) < 7);
         if (m_req_valid && m_req_ready && !resp_pending && !free_next) begin
            resp_pending = 1'b1;
            resp_delay   = $urandom_range(0, 2);
         end
         // requesters
         iv          = ($urandom_range(0, 9) < 6);
         dv          = ($urandom_range(0, 9) < 6);
         i_req_valid = iv;
         i_req_addr  = $urandom;
         d_req_valid = dv;
         d_req_addr  = $urandom;
         d_req_wdata = $urandom;
         d_req_fcn   = 1'($urandom_range(0, 1));
         d_req_typ   = 3'($urandom_range(0, 7));
         exp_i_rdy   = 1'b0;
         exp_d_rdy   = 1'b0;
         if (model_free && (iv || dv)) begin
            if (iv && (!dv || starve == MAX_STARVE)) begin
               exp_req.push_back('{own: 1'b0, addr: i_req_addr, wdata: 32'h0,
                                   fcn: 1'b0, typ: 3'd6});
               starve    = 0;
               exp_i_rdy = 1'b1;
               cur_owner = 1'b0;
            end else begin
               exp_req.push_back('{own: 1'b1, addr: d_req_addr, wdata: d_req_wdata,
                                   fcn: d_req_fcn, typ: d_req_typ});
               if (iv && starve < MAX_STARVE) starve++;
               exp_d_rdy = 1'b1;
               cur_owner = 1'b1;
            end
            model_free = 1'b0;
         end
      end
      env_on = 1'b0;
      @(negedge clk);
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      m_res_valid = 1'b0;
      m_req_ready = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      i_req_valid = 1'b0; i_req_addr  = '0;
      d_req_valid = 1'b0; d_req_addr  = '0; d_req_wdata = '0;
      d_req_fcn   = 1'b0; d_req_typ   = '0;
      m_req_ready = 1'b0; m_res_valid = 1'b0; m_res_data = '0;
      exp_i_rdy   = 1'b0; exp_d_rdy   = 1'b0; exp_err    = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_readies", {i_req_ready, d_req_ready}, 2'b00);
      check("rst_valids", {m_req_valid, i_res_valid, d_res_valid, err_spurious}, 4'b0000);
      check("rst_owner", owner, 1'b0);
      check("rst_fields", {m_req_addr, m_req_wdata}, 64'h0);
      check("rst_fcn_typ", {m_req_fcn, m_req_typ}, 4'h0);

      // I-only fetch, zero-wait memory
      @(negedge clk);
      i_req_valid = 1'b1; i_req_addr = 32'h100;
      #1;
      check("ionly_i_ready_N", i_req_ready, 1'b1);
      check("ionly_d_ready_N", d_req_ready, 1'b0);
      @(negedge clk);
      i_req_valid = 1'b0; m_req_ready = 1'b1;
      #1;
      check("ionly_m_valid_N1", m_req_valid, 1'b1);
      check("ionly_m_addr", m_req_addr, 32'h100);
      check("ionly_m_typ", m_req_typ, 3'd6);
      check("ionly_m_fcn", m_req_fcn, 1'b0);
      check("ionly_m_wdata", m_req_wdata, 32'h0);
      check("ionly_owner", owner, 1'b0);
      @(negedge clk);
      m_req_ready = 1'b0; m_res_valid = 1'b1; m_res_data = 32'hDEADBEEF;
      #1;
      check("ionly_i_res_valid_N2", i_res_valid, 1'b1);
      check("ionly_i_res_data", i_res_data, 32'hDEADBEEF);
      check("ionly_d_res_valid", d_res_valid, 1'b0);
      check("ionly_m_valid_N2", m_req_valid, 1'b0);

      // I and D together: D store wins, I follows
      @(negedge clk);
      m_res_valid = 1'b0;
      i_req_valid = 1'b1; i_req_addr = 32'h300;
      d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_wdata = 32'h55;
      d_req_fcn   = 1'b1; d_req_typ  = 3'd2;
      #1;
      check("prio_d_ready", d_req_ready, 1'b1);
      check("prio_i_ready", i_req_ready, 1'b0);
      @(negedge clk);
      d_req_valid = 1'b0; m_req_ready = 1'b1;
      #1;
      check("prio_m_fcn", m_req_fcn, 1'b1);
      check("prio_m_addr", m_req_addr, 32'h200);
      check("prio_m_wdata", m_req_wdata, 32'h55);
      check("prio_m_typ", m_req_typ, 3'd2);
      check("prio_owner", owner, 1'b1);
      check("prio_i_ready_issue", i_req_ready, 1'b0);
      @(negedge clk);
      m_req_ready = 1'b0; m_res_valid = 1'b1; m_res_data = 32'h1234;
      #1;
      check("prio_d_res_valid", d_res_valid, 1'b1);
      check("prio_i_res_valid", i_res_valid, 1'b0);
      check("prio_d_res_data", d_res_data, 32'h1234);
      @(negedge clk);
      m_res_valid = 1'b0;
      #1;
      check("prio_i_second", i_req_ready, 1'b1);

      // downstream stall: fetch of 0x300 sits in ISSUE for 5 cycles
      @(negedge clk);
      d_req_valid = 1'b1; d_req_addr = 32'h999;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("stall_m_valid", m_req_valid, 1'b1);
         check("stall_m_addr", m_req_addr, 32'h300);
         check("stall_m_typ", m_req_typ, 3'd6);
         check("stall_readies", {i_req_ready, d_req_ready}, 2'b00);
         @(negedge clk);
      end
      i_req_valid = 1'b0; d_req_valid = 1'b0; m_req_ready = 1'b1;
      #1;
      check("stall_m_valid_6th", m_req_valid, 1'b1);
      check("stall_m_addr_6th", m_req_addr, 32'h300);
      @(negedge clk);
      m_req_ready = 1'b0; m_res_valid = 1'b1; m_res_data = 32'hCAFE0001;
      #1;
      check("stall_i_res_valid", i_res_valid, 1'b1);
      check("stall_i_res_data", i_res_data, 32'hCAFE0001);

      // spurious response in IDLE
      @(negedge clk);
      m_res_valid = 1'b1; m_res_data = 32'h77;
      #1;
      check("spur_err", err_spurious, 1'b1);
      check("spur_res_valids", {i_res_valid, d_res_valid}, 2'b00);
      @(negedge clk);
      m_res_valid = 1'b0;
      #1;
      check("spur_err_clear", err_spurious, 1'b0);

      // reset while waiting for a D response
      @(negedge clk);
      d_req_valid = 1'b1; d_req_addr = 32'h400; d_req_fcn = 1'b0; d_req_typ = 3'd2;
      #1;
      check("rstmid_d_ready", d_req_ready, 1'b1);
      @(negedge clk);
      d_req_valid = 1'b0; m_req_ready = 1'b1;
      @(negedge clk);
      m_req_ready = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rstmid_m_valid", m_req_valid, 1'b0);
      check("rstmid_owner", owner, 1'b0);
      check("rstmid_m_addr", m_req_addr, 32'h0);
      check("rstmid_res_valids", {i_res_valid, d_res_valid, err_spurious}, 3'b000);
      @(negedge clk);
      m_res_valid = 1'b1; m_res_data = 32'hBAD;
      #1;
      check("rstmid_late_err", err_spurious, 1'b1);
      check("rstmid_late_res", {i_res_valid, d_res_valid}, 2'b00);
      @(negedge clk);
      m_res_valid = 1'b0;

      // randomized phase against the transaction-level model
      run_random(3000);
      check("rand_liveness", n_resp >= 100, 1'b1);
      check("rand_req_drained", exp_req.size() <= 1, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
